// File: rtl/xor128_rng_arbiter.sv
// Shared xorshift128 source, handed out round-robin to NREQ requesters.
// Optional statistics ports (ack count, starvation flags) under RNG_ARB_STAT_EN.
module xor128_rng_arbiter #(
    parameter int          NREQ   = 4,
    parameter int          WARMUP = 16,
    parameter logic [31:0] SEED0  = 32'd123456789,
    parameter logic [31:0] SEED1  = 32'd362436069,
    parameter logic [31:0] SEED2  = 32'd521288629,
    parameter logic [31:0] SEED3  = 32'd88675123
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [NREQ-1:0]   iReq,
    output logic [NREQ-1:0]   oAck,
    output logic [31:0]       oData,
    input  logic              iSeedLoad,
    input  logic [127:0]      iSeed,
    output logic              oBusy
`ifdef RNG_ARB_STAT_EN
    ,
    output logic [31:0]       oCount,
    output logic [NREQ-1:0]   oStarve
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CW-1:0] WLAST   = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    typedef enum logic {S_WARM, S_RUN} state_t;
    localparam state_t S_INIT = (WARMUP == 0) ? S_RUN : S_WARM;

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_x, r_y, r_z, r_w;
    logic [CW-1:0]   r_warm;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_ack;
    logic [31:0]     r_data;

    logic [31:0]     w_t, w_wn;
    logic            w_step, w_grant, w_any;
    logic [PW-1:0]   w_win;
    logic [NREQ-1:0] w_onehot;
    int              w_idx;

    assign w_t  = r_x ^ (r_x << 11);
    assign w_wn = r_w ^ (r_w >> 19) ^ w_t ^ (w_t >> 8);

    // Walk from farthest to nearest so the last hit is the first set bit after r_ptr.
    always_comb begin
        w_win    = r_ptr;
        w_any    = 1'b0;
        w_idx    = 0;
        w_onehot = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (iReq[w_idx]) begin
                w_win = PW'(w_idx);
                w_any = 1'b1;
            end
        end
        w_onehot[w_win] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_grant     = 1'b0;
        if (iSeedLoad) begin
            w_state_nxt = S_INIT;
        end else begin
            case (r_state)
                S_WARM: begin
                    w_step = 1'b1;
                    if (r_warm == WLAST) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    w_step  = w_any;
                    w_grant = w_any;
                end
                default: w_state_nxt = S_INIT;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_INIT;
            r_x     <= SEED0;
            r_y     <= SEED1;
            r_z     <= SEED2;
            r_w     <= SEED3;
            r_warm  <= '0;
            r_ptr   <= PTR_RST;
            r_ack   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= '0;
            if (iSeedLoad) begin
                // All-zero state is a fixed point of the generator; fall back to defaults.
                if (iSeed == '0) {r_w, r_z, r_y, r_x} <= {SEED3, SEED2, SEED1, SEED0};
                else             {r_w, r_z, r_y, r_x} <= iSeed;
                r_warm <= '0;
            end else begin
                if (w_step) begin
                    r_x <= r_y;
                    r_y <= r_z;
                    r_z <= r_w;
                    r_w <= w_wn;
                end
                if (r_state == S_WARM) r_warm <= r_warm + 1'b1;
                if (w_grant) begin
                    r_ack  <= w_onehot;
                    r_data <= w_wn;
                    r_ptr  <= w_win;
                end
            end
        end
    end

    assign oAck  = r_ack;
    assign oData = r_data;
    assign oBusy = (r_state == S_WARM);

`ifdef RNG_ARB_STAT_EN
    localparam int SW = $clog2(NREQ + 2);
    localparam logic [SW-1:0] WAIT_SAT = SW'(NREQ + 1);
    localparam logic [SW-1:0] WAIT_LIM = SW'(NREQ);

    logic [31:0]     r_count;
    logic [NREQ-1:0] r_starve;
    logic [SW-1:0]   r_wait [NREQ];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_count  <= '0;
            r_starve <= '0;
            for (int i = 0; i < NREQ; i++) r_wait[i] <= '0;
        end else if (iSeedLoad) begin
            r_count  <= '0;
            r_starve <= '0;
            for (int i = 0; i < NREQ; i++) r_wait[i] <= '0;
        end else begin
            if (w_grant) r_count <= r_count + 32'd1;
            for (int i = 0; i < NREQ; i++) begin
                if (r_state == S_RUN && iReq[i] && !(w_grant && w_win == PW'(i))) begin
                    if (r_wait[i] != WAIT_SAT) r_wait[i] <= r_wait[i] + 1'b1;
                    r_starve[i] <= (r_wait[i] >= WAIT_LIM);
                end else begin
                    r_wait[i]   <= '0;
                    r_starve[i] <= 1'b0;
                end
            end
        end
    end

    assign oCount  = r_count;
    assign oStarve = r_starve;
`endif

endmodule

// File: tb/tb_xor128_rng_arbiter.sv
// Directed bench: one instance with WARMUP=0 (vector table), one with WARMUP=16.
module tb_xor128_rng_arbiter;

    logic         iClk = 1'b0;
    logic         iRst_n = 1'b0;
    logic [3:0]   req0 = '0, req16 = '0;
    logic         sl0 = 1'b0, sl16 = 1'b0;
    logic [127:0] seed0 = '0, seed16 = '0;
    logic [3:0]   ack0, ack16;
    logic [31:0]  data0, data16;
    logic         busy0, busy16;
`ifdef RNG_ARB_STAT_EN
    logic [31:0]  cnt0, cnt16;
    logic [3:0]   stv0, stv16;
`endif

    int total = 0;
    int bad = 0;

    always #5 iClk = ~iClk;

    xor128_rng_arbiter #(.NREQ(4), .WARMUP(0)) dut0 (
        .iClk(iClk), .iRst_n(iRst_n), .iReq(req0), .oAck(ack0), .oData(data0),
        .iSeedLoad(sl0), .iSeed(seed0), .oBusy(busy0)
`ifdef RNG_ARB_STAT_EN
        , .oCount(cnt0), .oStarve(stv0)
`endif
    );

    xor128_rng_arbiter #(.NREQ(4), .WARMUP(16)) dut16 (
        .iClk(iClk), .iRst_n(iRst_n), .iReq(req16), .oAck(ack16), .oData(data16),
        .iSeedLoad(sl16), .iSeed(seed16), .oBusy(busy16)
`ifdef RNG_ARB_STAT_EN
        , .oCount(cnt16), .oStarve(stv16)
`endif
    );

    typedef struct {
        logic [3:0]   req;
        logic         sl;
        logic [127:0] seed;
        logic [3:0]   ack;
        logic [31:0]  data;
    } vec_t;

    vec_t        tbl [17];
    logic [31:0] refv [41];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        logic [31:0] mx, my, mz, mw, mt;
        mx = 32'd123456789; my = 32'd362436069; mz = 32'd521288629; mw = 32'd88675123;
        refv[0] = '0;
        for (int k = 1; k <= 40; k++) begin
            mt = mx ^ (mx << 11);
            mx = my; my = mz; mz = mw;
            mw = mw ^ (mw >> 19) ^ mt ^ (mt >> 8);
            refv[k] = mw;
        end

        tbl[0]  = '{4'b0001, 1'b0, 128'd0, 4'b0001, 32'd3701687786};
        tbl[1]  = '{4'b0001, 1'b0, 128'd0, 4'b0001, 32'd458299110};
        tbl[2]  = '{4'b0001, 1'b0, 128'd0, 4'b0001, 32'd2500872618};
        tbl[3]  = '{4'b0010, 1'b0, 128'd0, 4'b0010, refv[4]};
        tbl[4]  = '{4'b1010, 1'b0, 128'd0, 4'b1000, refv[5]};
        tbl[5]  = '{4'b1010, 1'b0, 128'd0, 4'b0010, refv[6]};
        tbl[6]  = '{4'b1010, 1'b0, 128'd0, 4'b1000, refv[7]};
        tbl[7]  = '{4'b1010, 1'b0, 128'd0, 4'b0010, refv[8]};
        tbl[8]  = '{4'b0010, 1'b0, 128'd0, 4'b0010, refv[9]};
        tbl[9]  = '{4'b0010, 1'b0, 128'd0, 4'b0010, refv[10]};
        tbl[10] = '{4'b0000, 1'b0, 128'd0, 4'b0000, refv[10]};
        tbl[11] = '{4'b0010, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b0000, refv[10]};
        tbl[12] = '{4'b0010, 1'b0, 128'd0, 4'b0010, 32'h0000080D};
        tbl[13] = '{4'b0100, 1'b1, 128'd0, 4'b0000, 32'h0000080D};
        tbl[14] = '{4'b0100, 1'b0, 128'd0, 4'b0100, 32'd3701687786};
        tbl[15] = '{4'b0100, 1'b0, 128'd0, 4'b0100, 32'd458299110};
        tbl[16] = '{4'b0100, 1'b0, 128'd0, 4'b0100, 32'd2500872618};

        // Reset state
        req16 = 4'b1111;
        #12;
        chk("rst ack0", 32'(ack0), 32'd0);
        chk("rst data0", data0, 32'd0);
        chk("rst busy0", 32'(busy0), 32'd0);
        chk("rst busy16", 32'(busy16), 32'd1);
        chk("rst ack16", 32'(ack16), 32'd0);
        @(negedge iClk);
        iRst_n = 1'b1;

        // Warm-up: 16 busy cycles with requests ignored, then round-robin grants
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("warm busy %0d", i), 32'(busy16), 32'd1);
            chk($sformatf("warm ack %0d", i), 32'(ack16), 32'd0);
            tick();
        end
        chk("warm done busy", 32'(busy16), 32'd0);
        chk("warm done ack", 32'(ack16), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("rr ack %0d", k), 32'(ack16), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr data %0d", k), data16, refv[17 + k]);
        end
        req16 = 4'b0000;

        // Table on the WARMUP=0 instance
        for (int i = 0; i < 17; i++) begin
            req0  = tbl[i].req;
            sl0   = tbl[i].sl;
            seed0 = tbl[i].seed;
            tick();
            sl0 = 1'b0;
            chk($sformatf("vec%0d ack", i), 32'(ack0), 32'(tbl[i].ack));
            chk($sformatf("vec%0d data", i), data0, tbl[i].data);
            if (tbl[i].sl) chk($sformatf("vec%0d busy", i), 32'(busy0), 32'd0);
        end

        // Async reset while oAck=0100 is showing
        #2;
        iRst_n = 1'b0;
        #1;
        chk("async rst ack0", 32'(ack0), 32'd0);
        chk("async rst data0", data0, 32'd0);
        chk("async rst busy16", 32'(busy16), 32'd1);
        req0 = 4'b0001;
        @(negedge iClk);
        iRst_n = 1'b1;
        tick();
        chk("post rst ack0", 32'(ack0), 32'd1);
        chk("post rst data0", data0, 32'd3701687786);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
